// File: rtl/rr_mux4x1_if.sv
// Four source channels plus one registered output channel for the round-robin mux.
// The slave modport is the mux side; the master modport is the producer/consumer side.
interface rr_mux4x1_if #(
  parameter int unsigned WIDTH = 8
);
  logic [4*WIDTH-1:0] dataIn;
  logic [3:0]         validIn;
  logic [3:0]         readyIn;
  logic [WIDTH-1:0]   dataOut;
  logic [1:0]         sel;
  logic               validOut;
  logic               readyOut;

  modport slave (
    input  dataIn,
    input  validIn,
    output readyIn,
    output dataOut,
    output sel,
    output validOut,
    input  readyOut
  );

  modport master (
    output dataIn,
    output validIn,
    input  readyIn,
    input  dataOut,
    input  sel,
    input  validOut,
    output readyOut
  );
endinterface

// File: rtl/rr_mux4x1.sv
// Four-into-one round-robin multiplexer with a single registered output slot.
// Each forwarded word is tagged with the index of the channel it came from.
module rr_mux4x1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  rr_mux4x1_if.slave  ch_io
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, grant_data;
  logic [1:0]       sel_q, sel_d, last_q, last_d;
  logic [1:0]       grant, idx;
  logic             found, load;

  // Search starts one past the last granted channel and wraps.
  always_comb begin
    grant = last_q;
    found = 1'b0;
    idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && ch_io.validIn[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    unique case (grant)
      2'd0: grant_data = ch_io.dataIn[0*WIDTH +: WIDTH];
      2'd1: grant_data = ch_io.dataIn[1*WIDTH +: WIDTH];
      2'd2: grant_data = ch_io.dataIn[2*WIDTH +: WIDTH];
      2'd3: grant_data = ch_io.dataIn[3*WIDTH +: WIDTH];
      default: grant_data = '0;
    endcase
  end

  // Gated by resetn so no handshake can complete while reset is held.
  assign load = resetn && ((state_q == StEmpty) || ch_io.readyOut) && found;

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    sel_d         = sel_q;
    last_d        = last_q;
    ch_io.readyIn = 4'b0000;
    if (load) begin
      ch_io.readyIn[grant] = 1'b1;
      state_d              = StFull;
      data_d               = grant_data;
      sel_d                = grant;
      last_d               = grant;
    end else if ((state_q == StFull) && ch_io.readyOut) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StEmpty;
      data_q  <= '0;
      sel_q   <= 2'b00;
      last_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign ch_io.dataOut  = data_q;
  assign ch_io.sel      = sel_q;
  assign ch_io.validOut = (state_q == StFull);

endmodule

// File: tb/tb_rr_mux4x1.sv
// Bench for rr_mux4x1: a reference model predicts grants and pushes the expected
// output slot to a queue each cycle; tests pop and compare after the clock edge.
module tb_rr_mux4x1;
  localparam int unsigned W = 8;

  logic clk;
  logic resetn;
  rr_mux4x1_if #(.WIDTH(W)) bus ();

  rr_mux4x1 #(.WIDTH(W)) dut (
    .clk   (clk),
    .resetn(resetn),
    .ch_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state and scoreboard of expected {validOut, sel, dataOut}.
  logic         m_valid;
  logic [1:0]   m_sel;
  logic [W-1:0] m_data;
  logic [1:0]   m_last;
  logic [10:0]  sb_q[$];

  function automatic void model_reset();
    m_valid = 1'b0;
    m_sel   = 2'd0;
    m_data  = '0;
    m_last  = 2'd3;
    sb_q.delete();
  endfunction

  // Drive one cycle: predict readyIn and the post-edge slot, then clock.
  task automatic step(input logic [3:0] v, input logic ro,
                      output logic [3:0] exp_rdy, output logic [3:0] got_rdy);
    logic [4*W-1:0] din;
    logic           ld;
    logic           hit;
    int             g;
    int             c;
    bus.validIn  = v;
    bus.readyOut = ro;
    #1;
    got_rdy = bus.readyIn;
    din     = bus.dataIn;
    hit     = 1'b0;
    g       = 0;
    for (int k = 1; k <= 4; k++) begin
      c = (int'(m_last) + k) % 4;
      if (!hit && v[c]) begin
        g   = c;
        hit = 1'b1;
      end
    end
    ld      = (!m_valid || ro) && hit;
    exp_rdy = ld ? (4'b0001 << g) : 4'b0000;
    if (ld) begin
      m_valid = 1'b1;
      m_sel   = 2'(g);
      m_data  = din[g*W +: W];
      m_last  = 2'(g);
    end else if (m_valid && ro) begin
      m_valid = 1'b0;
    end
    sb_q.push_back({m_valid, m_sel, m_data});
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn       = 1'b0;
    bus.validIn  = 4'b0000;
    bus.readyOut = 1'b0;
    bus.dataIn   = '0;
    @(posedge clk);
    #2;
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [3:0]  er, gr;
    logic [10:0] e;
    resetn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.validIn  = 4'($urandom);
      bus.readyOut = 1'($urandom);
      bus.dataIn   = 32'($urandom);
      #4;
      total++;
      if ({bus.validOut, bus.sel, bus.dataOut, bus.readyIn} !== 15'd0) begin
        bad++;
        $display("FAIL reset[%0d]: got v=%b sel=%0d d=%h rdy=%b, want all zero", i,
                 bus.validOut, bus.sel, bus.dataOut, bus.readyIn);
      end
    end
    bus.validIn  = 4'b0000;
    bus.readyOut = 1'b0;
    #3;
    resetn = 1'b1;
    model_reset();
    bus.dataIn = 32'h0000_0011;
    step(4'b0001, 1'b1, er, gr);
    total++;
    if (gr !== 4'b0001) begin
      bad++;
      $display("FAIL first_ready: got %b want 0001", gr);
    end
    e = sb_q.pop_front();
    total++;
    if ({bus.validOut, bus.sel, bus.dataOut} !== e || e !== 11'h411) begin
      bad++;
      $display("FAIL first_word: got %h want %h", {bus.validOut, bus.sel, bus.dataOut}, e);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  er, gr;
    logic [10:0] e;
    apply_reset();
    bus.dataIn = 32'hA3A2_A1A0;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, er, gr);
      total++;
      if (gr !== er) begin
        bad++;
        $display("FAIL rr_ready[%0d]: got %b want %b", i, gr, er);
      end
      e = sb_q.pop_front();
      total++;
      if ({bus.validOut, bus.sel, bus.dataOut} !== e || bus.sel !== 2'(i % 4)) begin
        bad++;
        $display("FAIL rr_out[%0d]: got %h want %h sel %0d", i,
                 {bus.validOut, bus.sel, bus.dataOut}, e, i % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  er, gr;
    logic [10:0] e;
    step(4'b1111, 1'b1, er, gr);
    e = sb_q.pop_front();
    total++;
    if ({bus.validOut, bus.sel, bus.dataOut} !== e || bus.dataOut !== 8'hA1) begin
      bad++;
      $display("FAIL bp_load: got %h want %h", {bus.validOut, bus.sel, bus.dataOut}, e);
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0, er, gr);
      total++;
      if (gr !== 4'b0000) begin
        bad++;
        $display("FAIL bp_ready[%0d]: got %b want 0000", i, gr);
      end
      e = sb_q.pop_front();
      total++;
      if ({bus.validOut, bus.sel, bus.dataOut} !== e || e !== 11'h5A1) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got %h want 5a1", i, {bus.validOut, bus.sel, bus.dataOut});
      end
    end
    step(4'b1111, 1'b1, er, gr);
    e = sb_q.pop_front();
    total++;
    if ({bus.validOut, bus.sel, bus.dataOut} !== e || e !== 11'h6A2) begin
      bad++;
      $display("FAIL bp_resume: got %h want 6a2", {bus.validOut, bus.sel, bus.dataOut});
    end
  endtask

  task automatic test_skip_wrap();
    logic [3:0]  er, gr;
    logic [10:0] e;
    logic [3:0]  want_rdy[3];
    want_rdy = '{4'b1000, 4'b0001, 4'b1000};
    apply_reset();
    bus.dataIn = 32'h3322_1100;
    step(4'b0010, 1'b1, er, gr);
    void'(sb_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      step(4'b1001, 1'b1, er, gr);
      total++;
      if (gr !== er || gr !== want_rdy[i]) begin
        bad++;
        $display("FAIL skip_ready[%0d]: got %b want %b", i, gr, want_rdy[i]);
      end
      e = sb_q.pop_front();
      total++;
      if ({bus.validOut, bus.sel, bus.dataOut} !== e) begin
        bad++;
        $display("FAIL skip_out[%0d]: got %h want %h", i, {bus.validOut, bus.sel, bus.dataOut}, e);
      end
    end
  endtask

  task automatic test_drain();
    logic [3:0]  er, gr;
    logic [10:0] e;
    apply_reset();
    bus.dataIn = 32'h0D5C_0B0A;
    step(4'b0100, 1'b1, er, gr);
    e = sb_q.pop_front();
    total++;
    if ({bus.validOut, bus.sel, bus.dataOut} !== e || e !== 11'h65C) begin
      bad++;
      $display("FAIL drain_load: got %h want 65c", {bus.validOut, bus.sel, bus.dataOut});
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b1, er, gr);
      e = sb_q.pop_front();
      total++;
      if ({bus.validOut, bus.sel, bus.dataOut} !== e || e !== 11'h25C) begin
        bad++;
        $display("FAIL drain_idle[%0d]: got %h want 25c", i, {bus.validOut, bus.sel, bus.dataOut});
      end
    end
    step(4'b0100, 1'b1, er, gr);
    total++;
    if (gr !== er || gr !== 4'b0100) begin
      bad++;
      $display("FAIL drain_regrant: got %b want 0100", gr);
    end
    void'(sb_q.pop_front());
    // With last=2 the pointer must pick channel 3 over channel 2.
    step(4'b1100, 1'b1, er, gr);
    total++;
    if (gr !== er || gr !== 4'b1000) begin
      bad++;
      $display("FAIL drain_pointer: got %b want 1000", gr);
    end
    e = sb_q.pop_front();
    total++;
    if ({bus.validOut, bus.sel, bus.dataOut} !== e) begin
      bad++;
      $display("FAIL drain_ptr_out: got %h want %h", {bus.validOut, bus.sel, bus.dataOut}, e);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0]  er, gr;
    logic [10:0] e;
    apply_reset();
    bus.dataIn = 32'hA3A2_A1A0;
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b1, er, gr);
      void'(sb_q.pop_front());
    end
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if (bus.validOut !== 1'b0 || bus.readyIn !== 4'b0000 || bus.dataOut !== 8'h00) begin
      bad++;
      $display("FAIL async_reset: got v=%b rdy=%b d=%h want 0 0000 00",
               bus.validOut, bus.readyIn, bus.dataOut);
    end
    @(posedge clk);
    #2;
    resetn = 1'b1;
    model_reset();
    step(4'b1111, 1'b1, er, gr);
    total++;
    if (gr !== 4'b0001) begin
      bad++;
      $display("FAIL async_first_ready: got %b want 0001", gr);
    end
    e = sb_q.pop_front();
    total++;
    if ({bus.validOut, bus.sel, bus.dataOut} !== e || e !== 11'h4A0) begin
      bad++;
      $display("FAIL async_first_word: got %h want 4a0", {bus.validOut, bus.sel, bus.dataOut});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  er, gr;
    logic [10:0] e;
    for (int i = 0; i < 60; i++) begin
      bus.dataIn = 32'($urandom);
      step(4'($urandom), 1'($urandom_range(0, 3) != 0), er, gr);
      total++;
      if (gr !== er) begin
        bad++;
        $display("FAIL rand_ready[%0d]: got %b want %b", i, gr, er);
      end
      e = sb_q.pop_front();
      total++;
      if ({bus.validOut, bus.sel, bus.dataOut} !== e) begin
        bad++;
        $display("FAIL rand_out[%0d]: got %h want %h", i, {bus.validOut, bus.sel, bus.dataOut}, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn       = 1'b0;
    bus.validIn  = 4'b0000;
    bus.readyOut = 1'b0;
    bus.dataIn   = '0;
    model_reset();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_skip_wrap();
    test_drain();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux4x1.md
Name: rr_mux4x1

Overview:
- Four-channel round-robin multiplexer; the gathering counterpart of the 2x4 demux/decoder.
- Collects words from four valid/ready source channels and forwards them, one at a time, onto a single registered output channel.
- Tags each forwarded word with the 2-bit index of its source channel, so a downstream demux can route on that index.
- Sits between four producers and one shared consumer (e.g. a shared UART transmitter or bus port).

Parameters:
- WIDTH, 8, data word width in bits for every channel.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- dataIn  input  4*WIDTH  channel i data occupies bits [i*WIDTH +: WIDTH].
- validIn  input  4  validIn[i] high: channel i presents a word.
- readyIn  output  4  readyIn[i] high: channel i word is accepted this cycle.
- dataOut  output  WIDTH  forwarded word (registered).
- sel  output  2  source channel index of dataOut (registered).
- validOut  output  1  dataOut/sel hold a word (registered).
- readyOut  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (resetn low, asynchronous):
  - validOut=0, dataOut=0, sel=2'b00, readyIn=4'b0000.
  - Round-robin pointer last=2'b11, so channel 0 has highest priority first.
  - Reset asserted mid-operation discards the held word; no handshake completes in that cycle.
- Two states:
  - EMPTY: validOut=0.
  - FULL: validOut=1.
- Load condition: load = (!validOut || readyOut) && |validIn.
- Grant:
  - Search order starts at channel last+1 mod 4 and wraps.
  - The first i with validIn[i]=1 is granted (g).
  - readyIn has exactly one bit set, readyIn[g], and only when load=1. Otherwise readyIn=0.
  - readyIn is combinational from validIn, validOut, readyOut and last. No output depends combinationally on dataIn.
- On a clock edge with load=1: dataOut<=dataIn[g*WIDTH +: WIDTH], sel<=g, validOut<=1, last<=g.
- On a clock edge with validOut=1, readyOut=1, and no valid input: validOut<=0. dataOut and sel keep their old values.
- FULL with readyOut=0 (stall): dataOut, sel and validOut stay stable, readyIn=0, last unchanged.
- Simultaneous drain and load (FULL, readyOut=1, some validIn=1): the output word is replaced in the same edge. Zero bubble.
  - Sustained throughput is one word per clock.
- Latency: a word accepted at edge N appears on dataOut/validOut immediately after edge N, i.e. 1 cycle.
- Fairness: while all four channels stay valid and readyOut=1, grants cycle 0,1,2,3,0,...
  - A channel that drops validIn is skipped without stalling.
- A channel whose validIn falls before being granted loses nothing; no state is kept per channel.
- last updates only on a grant. Idle cycles do not move priority.
- validOut never falls while readyOut=0 (no word is ever dropped).

Test Plan:
- Reset value check: hold resetn=0 with all inputs toggling. Expect validOut=0, dataOut=0, sel=0, readyIn=0000. Release reset.
  - Then validIn=0001 with dataIn ch0=0x11 -> readyIn=0001 that cycle; next cycle dataOut=0x11, sel=0, validOut=1.
- Round-robin, all valid: validIn=1111, channel i data = 0xA0+i, readyOut=1 throughout.
  - Expect sel sequence 0,1,2,3,0 on consecutive cycles, dataOut 0xA0,0xA1,0xA2,0xA3,0xA0, validOut continuously 1.
- Backpressure: FULL holding 0xA1/sel=1, then readyOut=0 for 3 cycles with validIn=1111.
  - Expect dataOut=0xA1, sel=1, readyIn=0000 for those 3 cycles.
  - Then readyOut=1 -> next word is channel 2 (0xA2).
- Skip and wrap: last=1, validIn=1001 -> grant ch3 (readyIn=1000), then ch0, then ch3 again.
- Drain to empty: single word from ch2 (0x5C), then validIn=0000 with readyOut=1.
  - Expect validOut=1 for exactly one cycle, then validOut=0 with sel=2 and dataOut=0x5C retained.
  - A later ch2 request is granted (priority pointer did not move during idle).
- Async reset mid-stream: during the all-valid round-robin, pulse resetn low between edges.
  - Expect validOut and readyIn to go 0 immediately, not waiting for an edge.
  - After release, the first grant goes to ch0.
